// File: rtl/avr_serial_pkg.sv
// Shared types and defaults for the FPGA-to-AVR serial transmitter.
package avr_serial_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned DefaultClkRate = 50_000_000;
  localparam int unsigned DefaultBaud    = 500_000;

  function automatic int unsigned clks_per_bit(input int unsigned clk_rate,
                                               input int unsigned baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/avr_tx_fifo.sv
// Byte FIFO for the serial transmitter; pointers carry one extra wrap bit.
module avr_tx_fifo #(
  parameter int unsigned AddrW = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [Depth];
  logic           push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/avr_serial_tx.sv
// 8N1 UART transmitter toward the AVR, held off by the AVR's rx-busy flag.
// Define AVR_SERIAL_TX_FIFO_EN to replace the holding register with a FIFO.
module avr_serial_tx
  import avr_serial_pkg::*;
#(
  parameter int unsigned CLK_RATE    = DefaultClkRate,
  parameter int unsigned BAUD        = DefaultBaud,
  parameter int unsigned FIFO_ADDR_W = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       new_data_i,
  output logic       ready_o,
  input  logic       avr_rx_busy_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_RATE, BAUD);
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  if (ClksPerBit < 2 || FIFO_ADDR_W < 1) begin : g_bad_cfg
    $error("avr_serial_tx: CLK_RATE/BAUD must be >= 2 and FIFO_ADDR_W >= 1");
  end

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            sync1_q, sync2_q;
  logic            init_q;
  logic            push, pop;
  logic            st_full, st_empty;
  logic [7:0]      st_data;

  assign ready_o = init_q && !st_full;
  assign push    = new_data_i && ready_o;
  assign pop     = (state_q == StIdle) && !st_empty && !sync2_q;
  assign busy_o  = (state_q != StIdle) || !st_empty;
  assign tx_o    = tx_q;

`ifdef AVR_SERIAL_TX_FIFO_EN
  avr_tx_fifo #(
    .AddrW (FIFO_ADDR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (data_i),
    .data_o  (st_data),
    .full_o  (st_full),
    .empty_o (st_empty)
  );
`else
  logic       hold_valid_q;
  logic [7:0] hold_data_q;

  // A push only happens while empty, so it never collides with a pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= data_i;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign st_full  = hold_valid_q;
  assign st_empty = !hold_valid_q;
  assign st_data  = hold_data_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      sync1_q <= avr_rx_busy_i;
      sync2_q <= sync1_q;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = st_data;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is computed from the next state so tx leaves a flop aligned with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
